// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state, burst-size encodings and burst-length helper for the memory arbiter
package mem_arb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_BURST = 2'd3
    } arb_state_t;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    function automatic logic [CNT_W-1:0] burst_len(input logic [1:0] acc);
        case (acc)
            ACC_1W:  return CNT_W'(1);
            ACC_4W:  return CNT_W'(4);
            ACC_8W:  return CNT_W'(8);
            default: return CNT_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and memory-side signals of the arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  if_acc_size;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic [31:0] dm_addr;
    logic [1:0]  dm_acc_size;
    logic        dm_wren;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_wnext;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_done;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [1:0]  mem_acc_size;
    logic        mem_wren;
    logic        mem_busy;
    logic        mem_enable;

    // requesters plus memory model
    modport master (
        output if_req, if_addr, if_acc_size, dm_req, dm_addr, dm_acc_size, dm_wren, dm_wdata,
               mem_data_out, mem_busy,
        input  if_gnt, if_rvalid, if_rdata, if_done, dm_gnt, dm_wnext, dm_rvalid, dm_rdata, dm_done,
               mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
    );

    modport slave (
        input  if_req, if_addr, if_acc_size, dm_req, dm_addr, dm_acc_size, dm_wren, dm_wdata,
               mem_data_out, mem_busy,
        output if_gnt, if_rvalid, if_rdata, if_done, dm_gnt, dm_wnext, dm_rvalid, dm_rdata, dm_done,
               mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
    );
endinterface

// File: rtl/mem_arb_beat_counter.sv
// rtl/mem_arb_beat_counter.sv - loadable down-counter for read latency and burst beats
module mem_arb_beat_counter
    import mem_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data burst arbiter for one memory port; MEM_ARB_STARVE_GUARD_EN enables fetch starvation guard
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clock,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    arb_state_t       state;
    logic             owner_dm;
    logic [CNT_W-1:0] load_val, if_len, dm_len;
    logic [31:0]      sel_addr;
    logic             cnt_load, cnt_dec, cnt_last;
    logic             starve_hit, grant, grant_dm, grant_if, wr_grant, beat, rd_beat, done;

    assign if_len   = burst_len(bus.if_acc_size);
    assign dm_len   = burst_len(bus.dm_acc_size);

    assign grant    = reset_n && state == ST_IDLE && !bus.mem_busy && (bus.if_req || bus.dm_req);
    assign grant_dm = grant && bus.dm_req && !(starve_hit && bus.if_req);
    assign grant_if = grant && !grant_dm;
    assign wr_grant = grant_dm && bus.dm_wren;
    assign sel_addr = grant_dm ? bus.dm_addr : bus.if_addr;

    // a beat is any unstalled burst cycle; word 0 of a write is taken in the grant cycle
    assign beat     = reset_n && !bus.mem_busy && (state == ST_WR_BURST || state == ST_RD_BURST);
    assign rd_beat  = beat && state == ST_RD_BURST;
    assign done     = (wr_grant && dm_len == CNT_W'(1)) || (beat && cnt_last);

    assign bus.if_gnt    = grant_if;
    assign bus.dm_gnt    = grant_dm;
    assign bus.dm_wnext  = wr_grant || (beat && state == ST_WR_BURST);
    assign bus.if_rvalid = rd_beat && !owner_dm;
    assign bus.dm_rvalid = rd_beat && owner_dm;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_data_out : 32'h0;
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_data_out : 32'h0;
    assign bus.dm_done   = done && (wr_grant || owner_dm);
    assign bus.if_done   = done && !wr_grant && !owner_dm;

    always_comb begin
        cnt_load = 1'b0;
        load_val = '0;
        if (grant) begin
            cnt_load = 1'b1;
            if (wr_grant)
                load_val = dm_len - CNT_W'(1);
            else if (RD_LATENCY == 0)
                load_val = grant_dm ? dm_len : if_len;
            else
                load_val = CNT_W'(RD_LATENCY);
        end else if (state == ST_RD_WAIT && cnt_last) begin
            cnt_load = 1'b1;
            load_val = burst_len(bus.mem_acc_size);
        end
    end

    assign cnt_dec = beat || state == ST_RD_WAIT;

    mem_arb_beat_counter u_beat_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = starve_cnt >= CNT_W'(STARVE_LIMIT);

    always_ff @(posedge clock) begin
        if (!reset_n || !bus.if_req || grant_if)
            starve_cnt <= '0;
        else if (grant_dm && !starve_hit)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end
`else
    // guard compiled out: data port always wins a tie
    assign starve_hit = 1'b0 && (STARVE_LIMIT > 0);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            owner_dm         <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_acc_size <= '0;
            bus.mem_wren     <= 1'b0;
            bus.mem_data_in  <= '0;
            bus.mem_enable   <= 1'b0;
        end else begin
            bus.mem_enable <= 1'b1;
            if (bus.dm_wnext)
                bus.mem_data_in <= bus.dm_wdata;
            unique case (state)
                ST_IDLE: begin
                    bus.mem_wren <= 1'b0;
                    if (grant) begin
                        owner_dm         <= grant_dm;
                        bus.mem_addr     <= sel_addr & ~32'h3;
                        bus.mem_acc_size <= grant_dm ? bus.dm_acc_size : bus.if_acc_size;
                        bus.mem_wren     <= wr_grant;
                        if (wr_grant)
                            state <= (dm_len == CNT_W'(1)) ? ST_IDLE : ST_WR_BURST;
                        else if (RD_LATENCY == 0)
                            state <= ST_RD_BURST;
                        else
                            state <= ST_RD_WAIT;
                    end
                end
                ST_WR_BURST: if (beat && cnt_last) state <= ST_IDLE;
                ST_RD_WAIT:  if (cnt_last) state <= ST_RD_BURST;
                ST_RD_BURST: if (beat && cnt_last) state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2, meaning cycles from read command on mem_* to first valid mem_data_out word.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data-port grants tolerated while if_req is pending.
REQ-003 SHALL use one clock and a synchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have fetch-port inputs: if_req  in  1  read request; if_addr  in  32  byte address; if_acc_size  in  2  burst size.
REQ-005 SHALL have fetch-port outputs: if_gnt  out  1  grant pulse; if_rvalid  out  1  read word valid; if_rdata  out  32  read word; if_done  out  1  last-word pulse.
REQ-006 SHALL have data-port inputs: dm_req  in  1  request; dm_addr  in  32  byte address; dm_acc_size  in  2  burst size; dm_wren  in  1  1=write; dm_wdata  in  32  write word.
REQ-007 SHALL have data-port outputs: dm_gnt  out  1  grant pulse; dm_wnext  out  1  dm_wdata sampled this cycle; dm_rvalid  out  1  read word valid; dm_rdata  out  32  read word; dm_done  out  1  last-word pulse.
REQ-008 SHALL have memory-side ports: mem_addr  out  32; mem_data_in  out  32; mem_data_out  in  32; mem_acc_size  out  2; mem_wren  out  1; mem_busy  in  1; mem_enable  out  1.

Function
REQ-009 SHALL map acc_size 00/01/10/11 to bursts of 1/4/8/16 words.
REQ-010 SHALL implement states IDLE, WR_BURST, RD_WAIT, RD_BURST.
REQ-011 SHALL, in IDLE with mem_busy=0 and any request, grant in the same cycle (cycle G), pulse the winner's gnt for one cycle, and drive mem_addr (bits [1:0] forced to 0), mem_acc_size, and mem_wren as registered outputs from G+1.
REQ-012 SHALL give dm priority over if on simultaneous requests, except as modified by REQ-022.
REQ-013 SHALL treat the fetch port as read-only, with mem_wren=0 for all if grants.
REQ-014 SHALL, for writes (WR_BURST), sample dm_wdata word k in the k-th non-stalled cycle starting at G, with dm_wnext=1 exactly in those cycles; mem_data_in SHALL present it on the following cycle.
REQ-015 SHALL, for reads, wait RD_LATENCY cycles in RD_WAIT after G+1, then forward mem_data_out combinationally to the winner's rdata with rvalid=1 for N non-stalled cycles.
REQ-016 SHALL pulse done on the cycle of the last write sample or last read word and return to IDLE on the next cycle; a new grant is possible in that IDLE cycle.
REQ-017 SHALL, while mem_busy=1 in WR_BURST or RD_BURST, freeze the beat counter and hold wnext and rvalid at 0.
REQ-018 SHALL hold mem_addr constant for the whole burst.
REQ-019 SHALL ignore requester deassertion mid-burst; the burst always completes.
REQ-020 SHALL drive if_rdata and dm_rdata to 0 when the corresponding rvalid=0.

Reset
REQ-021 SHALL, with reset_n=0 at a rising edge, abort any burst without a done pulse, enter IDLE, clear counters, and drive all outputs to 0 (mem_enable=0); mem_enable SHALL be 1 from the first cycle after reset is released.

Configuration
REQ-022 SHALL, with MEM_ARB_STARVE_GUARD_EN defined, count consecutive dm grants while if_req=1, give the next grant to if once the count reaches STARVE_LIMIT, and clear the count on any if grant or when if_req=0; without the macro, dm has strict priority and no counter exists.

Structure
REQ-023 SHALL place the state enum, acc_size encodings, and the burst-length function in package mem_arb_pkg.
REQ-024 SHALL implement the beat/latency counting in sub-module mem_arb_beat_counter.

Verification
REQ-025 SHALL cover a single read: if_req, if_addr=0x80020000, acc_size=00 -> if_gnt at G, mem_addr=0x80020000 at G+1, if_rvalid and if_done at G+3.
REQ-026 SHALL cover a 4-word write: dm_wren=1, acc_size=01, words A0..A3 -> dm_wnext at G..G+3, mem_data_in=A0..A3 at G+1..G+4, dm_done at G+3.
REQ-027 SHALL cover simultaneous requests: if and dm requesting in the same cycle -> dm_gnt first; if_gnt in the IDLE cycle after dm_done.
REQ-028 SHALL cover starvation with MEM_ARB_STARVE_GUARD_EN defined: dm_req held with if_req=1 -> the 5th grant goes to if; without the macro, if is never granted.
REQ-029 SHALL cover a stall: mem_busy=1 for 2 cycles during a 16-word read -> rvalid gaps of 2 cycles, exactly 16 rvalid beats, done delayed by 2 cycles.
REQ-030 SHALL cover reset mid-burst: reset_n=0 during the 5th beat of an 8-word read -> all outputs 0, no done, IDLE after release.
